// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I hart with unified byte memory, 32 x 32 register
// file and a flat 4096-entry machine-mode CSR array. Only clk/rst are external.

// Unified byte memory: combinational 4-byte fetch and data read, byte-lane writes.
module rv32i_mem #(
  parameter int MEM_BYTES = 65536,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] iaddr,
  output logic [31:0]   idata,
  input  logic [AW-1:0] daddr,
  output logic [31:0]   rdata,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb
);
  logic [7:0] m [0:MEM_BYTES-1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      assign ia = iaddr + AW'(gi);
      assign da = daddr + AW'(gi);
      assign idata[8*gi +: 8] = m[ia];
      assign rdata[8*gi +: 8] = m[da];
    end
  endgenerate

  // Each enabled lane lands at daddr+lane, so misaligned stores need no special case.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) m[daddr + AW'(i)] <= wdata[8*i +: 8];
    end
  end
endmodule

module rv32i_core #(
  parameter int          MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;

  logic [31:0] pc;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] instr, rdata, pc_next, rd_val, csr_val, csr_old, csr_src;
  logic [31:0] r1, r2, alu_b, alu, load_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [AW-1:0] daddr;
  logic [3:0]  wstrb, mem_wstrb;
  logic        rd_we, csr_we, ecall, take;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1a, rs2a;
  logic [2:0]  f3;
  logic [11:0] caddr;

  rv32i_mem #(.MEM_BYTES(MEM_BYTES), .AW(AW)) memory (
    .clk   (clk),
    .iaddr (pc[AW-1:0]),
    .idata (instr),
    .daddr (daddr),
    .rdata (rdata),
    .wdata (r2),
    .wstrb (mem_wstrb)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1a   = instr[19:15];
  assign rs2a   = instr[24:20];
  assign caddr  = instr[31:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign r1 = (rs1a == 5'd0) ? 32'd0 : rs[rs1a];
  assign r2 = (rs2a == 5'd0) ? 32'd0 : rs[rs2a];

  // The instruction in flight during reset must not touch memory.
  assign mem_wstrb = rst ? 4'd0 : wstrb;

  assign csr_old = (caddr == CSR_MHARTID) ? 32'd0 : csr[caddr];
  assign csr_src = f3[2] ? {27'd0, rs1a} : r1;

  // ALU shared by OP and OP-IMM; instr[30] selects SUB (register form only) and SRA.
  always_comb begin
    alu_b = (opcode == OP_REG) ? r2 : imm_i;
    alu   = 32'd0;
    case (f3)
      3'd0: alu = (opcode == OP_REG && instr[30]) ? r1 - alu_b : r1 + alu_b;
      3'd1: alu = r1 << alu_b[4:0];
      3'd2: alu = {31'd0, $signed(r1) < $signed(alu_b)};
      3'd3: alu = {31'd0, r1 < alu_b};
      3'd4: alu = r1 ^ alu_b;
      3'd5: alu = instr[30] ? $unsigned($signed(r1) >>> alu_b[4:0]) : r1 >> alu_b[4:0];
      3'd6: alu = r1 | alu_b;
      default: alu = r1 & alu_b;
    endcase
  end

  // Branch condition and load extension, both decoded from funct3.
  always_comb begin
    take = 1'b0;
    case (f3)
      3'd0: take = (r1 == r2);
      3'd1: take = (r1 != r2);
      3'd4: take = ($signed(r1) < $signed(r2));
      3'd5: take = ($signed(r1) >= $signed(r2));
      3'd6: take = (r1 < r2);
      3'd7: take = (r1 >= r2);
      default: take = 1'b0;
    endcase
    case (f3)
      3'd0: load_val = {{24{rdata[7]}}, rdata[7:0]};
      3'd1: load_val = {{16{rdata[15]}}, rdata[15:0]};
      3'd4: load_val = {24'd0, rdata[7:0]};
      3'd5: load_val = {16'd0, rdata[15:0]};
      default: load_val = rdata;
    endcase
  end

  // Main decode: next pc, register/CSR write intent and store lanes.
  always_comb begin
    pc_next = pc + 32'd4;
    rd_we   = 1'b0;
    rd_val  = 32'd0;
    csr_we  = 1'b0;
    csr_val = 32'd0;
    ecall   = 1'b0;
    wstrb   = 4'd0;
    daddr   = AW'(r1 + imm_i);
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = pc + imm_j; end
      OP_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = (r1 + imm_i) & ~32'd1; end
      OP_BRANCH: if (take) pc_next = pc + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; rd_val = load_val; end
      OP_STORE: begin
        daddr = AW'(r1 + imm_s);
        case (f3[1:0])
          2'd0:    wstrb = 4'b0001;
          2'd1:    wstrb = 4'b0011;
          default: wstrb = 4'b1111;
        endcase
      end
      OP_IMM, OP_REG: begin rd_we = 1'b1; rd_val = alu; end
      OP_SYSTEM: begin
        if (f3 == 3'd0) begin
          if (caddr == 12'h000) begin
            ecall   = 1'b1;
            pc_next = csr[CSR_MTVEC] & ~32'd3;
          end else if (caddr == 12'h302) begin
            pc_next = csr[CSR_MEPC];
          end
        end else if (f3[1:0] != 2'd0) begin
          rd_we  = 1'b1;
          rd_val = csr_old;
          csr_we = (caddr != CSR_MHARTID) && ((f3[1:0] == 2'd1) || (rs1a != 5'd0));
          case (f3[1:0])
            2'd1:    csr_val = csr_src;
            2'd2:    csr_val = csr_old | csr_src;
            default: csr_val = csr_old & ~csr_src;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Architectural commit: pc, register file and CSRs update on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
      csr[CSR_MSTATUS] <= 32'd0;
      csr[CSR_MTVEC]   <= 32'd0;
      csr[CSR_MEPC]    <= 32'd0;
      csr[CSR_MCAUSE]  <= 32'd0;
    end else begin
      pc <= pc_next;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
      if (csr_we) csr[caddr] <= csr_val;
      if (ecall) begin
        csr[CSR_MEPC]   <= pc;
        csr[CSR_MCAUSE] <= 32'd11;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs plus random instruction streams, each run in
// lockstep against an instruction-level model of the ISA kept in the bench.
module tb_rv32i_core;
  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32i_core #(.MEM_BYTES(65536), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instruction-set model state
  logic [7:0]  mm   [0:65535];
  logic [31:0] xr   [0:31];
  logic [31:0] mcsr [0:4095];
  logic [31:0] mpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(int imm, int r1, int f3, int rd, logic [6:0] op);
    logic [31:0] v; v = imm;
    return {v[11:0], 5'(r1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int r2, int r1, int f3, int rd);
    return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int r2, int r1, int f3);
    logic [31:0] v; v = imm;
    return {v[11:5], 5'(r2), 5'(r1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int r2, int r1, int f3);
    logic [31:0] v; v = imm;
    return {v[12], v[10:5], 5'(r2), 5'(r1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    logic [31:0] v; v = imm;
    return {v[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v; v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;

  // ---------------- model ----------------
  function automatic logic [7:0] rd8(input logic [31:0] a);
    return mm[a[15:0]];
  endfunction
  function automatic logic [31:0] rd32(input logic [31:0] a);
    return {rd8(a + 3), rd8(a + 2), rd8(a + 1), rd8(a)};
  endfunction

  function automatic logic [31:0] model_alu(input logic [2:0] f3, input logic [31:0] x,
                                            input logic [31:0] y, input logic alt);
    int sh; sh = int'(y[4:0]);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return (alt && x[31] && sh != 0) ? ((x >> sh) | (32'hFFFF_FFFF << (32 - sh))) : (x >> sh);
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) xr[i] = 32'd0;
    mpc = 32'd0;
    mcsr[12'h300] = 0; mcsr[12'h305] = 0; mcsr[12'h341] = 0; mcsr[12'h342] = 0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, ii, res, nxt, ea, ov, src, h;
    logic [2:0] f3; logic [4:0] rd, ra; logic [11:0] ca; logic wr, tk; int nb;
    ins = rd32(mpc);
    f3 = ins[14:12]; rd = ins[11:7]; ra = ins[19:15]; ca = ins[31:20];
    a = xr[ra]; b = xr[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    nxt = mpc + 4; wr = 1'b0; res = 32'd0;
    case (ins[6:0])
      7'h37: begin wr = 1; res = {ins[31:12], 12'h0}; end
      7'h17: begin wr = 1; res = mpc + {ins[31:12], 12'h0}; end
      7'h6F: begin wr = 1; res = mpc + 4;
        nxt = mpc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h67: begin wr = 1; res = mpc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = a == b;
          3'd1: tk = a != b;
          3'd4: tk = int'(a) < int'(b);
          3'd5: tk = int'(a) >= int'(b);
          3'd6: tk = a < b;
          3'd7: tk = a >= b;
          default: tk = 0;
        endcase
        if (tk) nxt = mpc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h03: begin
        ea = a + ii; wr = 1; h = {rd8(ea + 1), rd8(ea)};
        case (f3)
          3'd0: res = {{24{h[7]}}, h[7:0]};
          3'd1: res = {{16{h[15]}}, h[15:0]};
          3'd4: res = {24'd0, h[7:0]};
          3'd5: res = {16'd0, h[15:0]};
          default: res = rd32(ea);
        endcase
      end
      7'h23: begin
        ea = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
        nb = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
          h = ea + k;
          mm[h[15:0]] = b[8*k +: 8];
        end
      end
      7'h13: begin wr = 1; res = model_alu(f3, a, ii, f3 == 3'd5 && ins[30]); end
      7'h33: begin wr = 1; res = model_alu(f3, a, b, ins[30] && (f3 == 3'd0 || f3 == 3'd5)); end
      7'h73: begin
        if (f3 == 3'd0) begin
          if (ca == 12'h000) begin
            mcsr[12'h341] = mpc; mcsr[12'h342] = 11; nxt = mcsr[12'h305] & ~32'd3;
          end else if (ca == 12'h302) nxt = mcsr[12'h341];
        end else if (f3[1:0] != 0) begin
          ov = (ca == 12'hF14) ? 32'd0 : mcsr[ca];
          wr = 1; res = ov;
          src = f3[2] ? {27'd0, ra} : a;
          if (ca != 12'hF14) begin
            if (f3[1:0] == 1) mcsr[ca] = src;
            else if (ra != 0) mcsr[ca] = (f3[1:0] == 2) ? (ov | src) : (ov & ~src);
          end
        end
      end
      default: ;
    endcase
    if (wr && rd != 0) xr[rd] = res;
    mpc = nxt;
  endtask

  // ---------------- helpers ----------------
  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      dut.memory.m[addr[15:0] + 16'(k)] = w[8*k +: 8];
      mm[addr[15:0] + 16'(k)] = w[8*k +: 8];
    end
  endtask

  task automatic put_prog(input logic [31:0] p []);
    for (int k = 0; k < p.size(); k++) put(32'(4 * k), p[k]);
  endtask

  task automatic start_test();
    rst = 1'b1;
    for (int k = 0; k < 'h1400; k++) begin dut.memory.m[k] = 8'd0; mm[k] = 8'd0; end
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", dut.pc, 32'h0);
    check("rst_x3", dut.rs[3], 32'h0);
    check("rst_mtvec", dut.csr[12'h305], 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_lockstep(input int n);
    for (int c = 0; c < n; c++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("pc", dut.pc, mpc);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), dut.rs[i], xr[i]);
    for (int a = 'h1000; a < 'h1104; a += 4)
      check($sformatf("mem%04h", a),
            {dut.memory.m[a+3], dut.memory.m[a+2], dut.memory.m[a+1], dut.memory.m[a]},
            {mm[a+3], mm[a+2], mm[a+1], mm[a]});
    check("mscratch", dut.csr[12'h340], mcsr[12'h340]);
  endtask

  function automatic logic [31:0] rand_instr();
    int rd, r1, r2, f3, sh, alt;
    int lf [5] = '{0, 1, 2, 4, 5};
    int bf [6] = '{0, 1, 4, 5, 6, 7};
    int cf [6] = '{1, 2, 3, 5, 6, 7};
    rd = $urandom_range(1, 30); r1 = $urandom_range(0, 31); r2 = $urandom_range(0, 31);
    f3 = $urandom_range(0, 7); sh = $urandom_range(0, 31); alt = $urandom_range(0, 1);
    case ($urandom_range(0, 9))
      0, 1: begin
        if (f3 == 1) return enc_i(sh, r1, 1, rd, 7'h13);
        if (f3 == 5) return enc_i((alt << 10) | sh, r1, 5, rd, 7'h13);
        return enc_i($urandom_range(0, 4095), r1, f3, rd, 7'h13);
      end
      2, 3: return enc_r(((f3 == 0 || f3 == 5) && alt == 1) ? 32 : 0, r2, r1, f3, rd);
      4: return enc_u($urandom, rd, 7'h37);
      5: return enc_u($urandom, rd, 7'h17);
      6: return enc_i($urandom_range(0, 255), 31, lf[$urandom_range(0, 4)], rd, 7'h03);
      7: return enc_s($urandom_range(0, 255), r2, 31, $urandom_range(0, 2));
      8: return enc_b(4 * $urandom_range(2, 4), r2, r1, bf[$urandom_range(0, 5)]);
      default: return enc_i(12'h340, r1, cf[$urandom_range(0, 5)], rd, 7'h73);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] prog [];
    int cyc;
    for (int i = 0; i < 4096; i++) mcsr[i] = 32'd0;

    // Reset mid-execution: a store in flight during reset must be dropped.
    start_test();
    prog = '{enc_i(8'h55, 0, 0, 1, 7'h13), enc_s(12'h100, 1, 0, 2)};
    put_prog(prog);
    release_rst();
    run_lockstep(1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_pc", dut.pc, 32'h0);
    check("midrst_x1", dut.rs[1], 32'h0);
    check("midrst_mem", {24'd0, dut.memory.m[16'h100]}, 32'h0);
    $display("test mid-execution reset done");

    // Branch not taken.
    start_test();
    prog = '{enc_i(5, 0, 0, 1, 7'h13), enc_i(5, 0, 0, 2, 7'h13), enc_b(8, 2, 1, 1), enc_i(1, 0, 0, 3, 7'h13)};
    put_prog(prog);
    release_rst();
    run_lockstep(4);
    check("bne_nt_x3", dut.rs[3], 32'd1);
    check("bne_nt_pc", dut.pc, 32'd16);
    $display("test bne not-taken done");

    // Branch taken.
    start_test();
    prog = '{enc_i(1, 0, 0, 1, 7'h13), enc_b(8, 0, 1, 1), enc_i(7, 0, 0, 5, 7'h13), enc_i(9, 0, 0, 6, 7'h13)};
    put_prog(prog);
    release_rst();
    run_lockstep(3);
    check("bne_t_x5", dut.rs[5], 32'd0);
    check("bne_t_x6", dut.rs[6], 32'd9);
    $display("test bne taken done");

    // Store word then sign/zero-extended byte and half loads.
    start_test();
    prog = '{enc_u(20'h80000, 1, 7'h37), enc_i(8'hFF, 1, 0, 1, 7'h13), enc_i(12'h100, 0, 0, 2, 7'h13),
             enc_s(0, 1, 2, 2), enc_i(0, 2, 0, 3, 7'h03), enc_i(0, 2, 4, 4, 7'h03),
             enc_i(0, 2, 1, 5, 7'h03), enc_i(3, 2, 0, 6, 7'h03)};
    put_prog(prog);
    release_rst();
    run_lockstep(8);
    check("lb", dut.rs[3], 32'hFFFF_FFFF);
    check("lbu", dut.rs[4], 32'h0000_00FF);
    check("lh", dut.rs[5], 32'h0000_00FF);
    check("lb3", dut.rs[6], 32'hFFFF_FF80);
    $display("test load/store done");

    // mtvec write, ECALL trap, MRET return.
    start_test();
    prog = '{enc_i(12'h40, 0, 0, 1, 7'h13), enc_i(12'h305, 1, 1, 0, 7'h73), NOP, NOP, NOP, NOP, NOP, NOP, ECALL};
    put_prog(prog);
    put(32'h40, MRET);
    release_rst();
    run_lockstep(9);
    check("ecall_pc", dut.pc, 32'h40);
    check("mepc", dut.csr[12'h341], 32'h20);
    check("mcause", dut.csr[12'h342], 32'd11);
    run_lockstep(1);
    check("mret_pc", dut.pc, 32'h20);
    $display("test ecall/mret done");

    // x0 is hardwired; SRAI sign-fills.
    start_test();
    prog = '{enc_i(5, 0, 0, 0, 7'h13), enc_r(0, 0, 0, 0, 1), enc_u(20'h80000, 2, 7'h37), enc_i(12'h404, 2, 5, 3, 7'h13)};
    put_prog(prog);
    release_rst();
    run_lockstep(4);
    check("x0", dut.rs[0], 32'h0);
    check("add_x0", dut.rs[1], 32'h0);
    check("srai", dut.rs[3], 32'hF800_0000);
    $display("test x0/srai done");

    // Self-checking BNE program: ends in ECALL with gp==1, trap handler spins at 0x200.
    start_test();
    prog = '{enc_i(12'h200, 0, 0, 1, 7'h13), enc_i(12'h305, 1, 1, 0, 7'h73), enc_i(2, 0, 0, 3, 7'h13),
             enc_i(0, 0, 0, 1, 7'h13), enc_i(1, 0, 0, 2, 7'h13), enc_b(8, 2, 1, 1), enc_j(32'h38, 0),
             enc_i(3, 0, 0, 3, 7'h13), enc_i(-1, 0, 0, 1, 7'h13), enc_i(1, 0, 0, 2, 7'h13),
             enc_b(8, 2, 1, 1), enc_j(32'h24, 0), enc_i(4, 0, 0, 3, 7'h13), enc_i(-1, 0, 0, 2, 7'h13),
             enc_b(32'h18, 2, 1, 1), enc_i(5, 0, 0, 3, 7'h13), enc_i(0, 0, 0, 1, 7'h13),
             enc_b(12, 0, 1, 1), enc_i(1, 0, 0, 3, 7'h13), ECALL, ECALL};
    put_prog(prog);
    put(32'h200, enc_j(0, 0));
    release_rst();
    cyc = 0;
    while (dut.pc != 32'h200 && cyc < 200) begin run_lockstep(1); cyc++; end
    check("bne_halt", dut.pc, 32'h200);
    check("bne_gp", dut.rs[3], 32'd1);
    check("bne_mcause", dut.csr[12'h342], 32'd11);
    check("bne_mepc", dut.csr[12'h341], 32'h4C);
    $display("test bne program done: gp=%0d", dut.rs[3]);

    // Random instruction streams.
    for (int t = 0; t < 6; t++) begin
      start_test();
      put(32'h0, enc_u(1, 31, 7'h37));
      put(32'h4, enc_i(12'h340, 0, 1, 0, 7'h73));
      for (int k = 2; k < 48; k++) put(32'(4 * k), rand_instr());
      release_rst();
      run_lockstep(48);
      compare_all();
      $display("test random program %0d done", t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I processor with a unified instruction/data memory, a 32-entry register file and a machine-mode CSR file.
- Self-contained top: only clock and reset are external.
- Program image is preloaded by the bench through hierarchical access.
- Runs riscv-tests "p"-environment binaries (e.g. rv32ui-p-bne); pass/fail is judged from register state.

Parameters:
- MEM_BYTES, 65536, size of unified memory in bytes; addresses wrap modulo MEM_BYTES.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.

Behaviour:
- Hierarchy is fixed so benches can preload and dump state:
  - Submodule instance "memory" holds array "m": MEM_BYTES x 8 bits, index 0..MEM_BYTES-1, one byte per hex entry, little-endian.
  - Register file is array "rs" [0:31] x 32.
  - CSR file is array "csr" [0:4095] x 32, indexed by the 12-bit CSR address.
- Reset (rst=1 at a rising edge):
  - pc <= RESET_PC.
  - All rs <= 0.
  - mstatus, mepc, mcause, mtvec <= 0; mhartid reads 0.
  - Memory contents are NOT cleared by reset.
- Execution: one instruction per clock, no stalls.
  - Fetch is a combinational 32-bit read of m[pc..pc+3].
  - Decode, execute and data read are combinational.
  - Register write, memory write, CSR write and pc update occur on the rising edge.
- x0: reads always return 0; writes are discarded.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops, FENCE/FENCE.I, ECALL, MRET, CSRRW/S/C and CSRRWI/SI/CI.
- Control flow:
  - Branch taken: pc <= pc + sext(imm_b); otherwise pc <= pc + 4.
  - JAL: rd <= pc+4, pc <= pc + imm_j.
  - JALR: rd <= pc+4, pc <= (rs1+imm_i) & ~1. rd==rs1 uses the old rs1.
- Loads and stores:
  - Byte/half loads are sign- or zero-extended per funct3.
  - Stores write only the addressed bytes.
  - Misaligned accesses are performed bytewise without a trap.
- ALU:
  - Shifts use the low 5 bits of the shift amount; SRA/SRAI are arithmetic.
  - SLT is signed; SLTU is unsigned.
  - Add/sub wrap modulo 2^32.
- CSR instructions:
  - rd <= old CSR value.
  - The new value is computed from rs1 or the zero-extended uimm.
  - CSRRS/CSRRC with rs1/uimm = 0 do not write.
- ECALL: mepc <= pc; mcause <= 11; pc <= mtvec & ~3. No register write.
- MRET: pc <= mepc.
- FENCE/FENCE.I: behave as NOP (pc+4).
- Any undecoded opcode: NOP, pc <= pc+4.
- Simultaneous events: a store to the word holding the next instruction takes effect before that instruction's fetch (the fetch happens in the following cycle).
- Reset mid-execution: the instruction in flight is discarded with no write.
- Test convention: a test passes when ECALL executes with x3 (gp) == 1. gp != 1 at ECALL means failure; test number = gp>>1.

Test Plan:
- Reset then preload "addi x1,x0,5; addi x2,x0,5; bne x1,x2,+8; addi x3,x0,1" -> branch not taken; after 4 cycles x3=1, pc=16.
- Preload "addi x1,x0,1; bne x1,x0,+8; addi x5,x0,7; addi x6,x0,9" -> branch taken; x5 stays 0, x6=9.
- Store 32'h8000_00FF with SW at address 0x100, then LB/LBU/LH from 0x100 -> 0xFFFF_FFFF, 0x0000_00FF, 0x0000_00FF; LB from 0x103 -> 0xFFFF_FF80.
- csrrw x0,mtvec with value 0x40, then ECALL at pc=0x20 -> pc=0x40, mepc=0x20, mcause=11; MRET -> pc=0x20.
- addi x0,x0,5 then add x1,x0,x0 -> x1=0; SRAI of 0x8000_0000 by 4 -> 0xF800_0000.
- Run the rv32ui-p-bne image for 5000 cycles -> ECALL reached with gp=1.
